// File: rtl/pam_access_arb.sv
// pam_access_arb
//
// Round-robin access arbiter in front of a register-based PAM (16 x 64-bit
// entries, three registered read ports, one byte-enabled write port).
// Each cycle it grants up to three reads and one write among NUM_REQ
// requesters, drives the PAM ports directly and returns read data to each
// requester one cycle after its grant.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_we           per-requester request present / write select
//   req_addr  [5i+:5]          entry address (addr[4]=1 is out of range)
//   req_be    [8i+:8]          byte enables for writes
//   req_wdata [64i+:64]        write data
//   req_ready                  combinational grant
//   rsp_valid/rsp_data/rsp_err read response one cycle after grant;
//                              rsp_err also flags out-of-range writes
//   pam_re0..2/pam_raddr0..2   PAM read ports (k-th in-range read uses port k)
//   pam_rdata0..2              PAM read data, valid the cycle after pam_re
//   pam_we/pam_be/pam_waddr/pam_wdata  PAM write port
//
// Optional feature: define PAM_ARB_BYPASS_EN to forward the same-cycle write
// into a read of the same in-range address (byte-merged). Without it, such a
// read returns the pre-write PAM contents.

module pam_access_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]  req_be,
  input  logic [64*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [64*NUM_REQ-1:0] rsp_data,
  output logic [NUM_REQ-1:0]    rsp_err,
  output logic                  pam_re0,
  output logic                  pam_re1,
  output logic                  pam_re2,
  output logic [4:0]            pam_raddr0,
  output logic [4:0]            pam_raddr1,
  output logic [4:0]            pam_raddr2,
  output logic                  pam_we,
  output logic [7:0]            pam_be,
  output logic [4:0]            pam_waddr,
  output logic [63:0]           pam_wdata,
  input  logic [63:0]           pam_rdata0,
  input  logic [63:0]           pam_rdata1,
  input  logic [63:0]           pam_rdata2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  // Requester index 'offs' places after 'base', wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                               input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  logic [4:0]  addr_a  [NUM_REQ];
  logic [7:0]  be_a    [NUM_REQ];
  logic [63:0] wdata_a [NUM_REQ];

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[5*g +: 5];
    assign be_a[g]    = req_be[8*g +: 8];
    assign wdata_a[g] = req_wdata[64*g +: 64];
  end

  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0]   wr_win, rd_last, idx;
  logic               wr_found, rd_any;
  logic [1:0]         rd_cnt, port_cnt;
  logic [2:0]         re_v;
  logic [4:0]         raddr_v [3];

  // Per-requester response bookkeeping: pending read, port used, out of range.
  logic [NUM_REQ-1:0] rsp_pend, rsp_oor, rsp_err_q;
  logic [1:0]         rsp_port [NUM_REQ];
  logic [NUM_REQ-1:0] pend_nxt, oor_nxt, err_nxt;
  logic [1:0]         port_nxt [NUM_REQ];

`ifdef PAM_ARB_BYPASS_EN
  logic [NUM_REQ-1:0] byp_nxt, byp_hit;
  logic [63:0]        byp_wdata, byp_mask;
  logic [7:0]         byp_be;
`endif

  // Arbitration. The write winner is found first so that reads can detect a
  // same-cycle write to their address. Out-of-range reads take one of the
  // three read grants but no PAM port, so the port counter only advances on
  // in-range winners.
  always_comb begin
    req_ready = '0;
    wr_found  = 1'b0;
    wr_win    = '0;
    rd_any    = 1'b0;
    rd_last   = '0;
    rd_cnt    = '0;
    port_cnt  = '0;
    re_v      = '0;
    idx       = '0;
    for (int p = 0; p < 3; p++) raddr_v[p] = '0;
    pend_nxt  = '0;
    oor_nxt   = '0;
    err_nxt   = '0;
    for (int i = 0; i < NUM_REQ; i++) port_nxt[i] = '0;
    pam_we    = 1'b0;
    pam_waddr = '0;
    pam_be    = '0;
    pam_wdata = '0;
`ifdef PAM_ARB_BYPASS_EN
    byp_nxt   = '0;
`endif

    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rot_idx(wr_ptr, k);
        if (!wr_found && req_valid[idx] && req_we[idx]) begin
          wr_found = 1'b1;
          wr_win   = idx;
        end
      end

      if (wr_found) begin
        req_ready[wr_win] = 1'b1;
        if (addr_a[wr_win][4]) begin
          err_nxt[wr_win] = 1'b1;
        end else begin
          pam_we    = 1'b1;
          pam_waddr = addr_a[wr_win];
          pam_be    = be_a[wr_win];
          pam_wdata = wdata_a[wr_win];
        end
      end

      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rot_idx(rd_ptr, k);
        if (rd_cnt != 2'd3 && req_valid[idx] && !req_we[idx]) begin
          req_ready[idx] = 1'b1;
          pend_nxt[idx]  = 1'b1;
          rd_any         = 1'b1;
          rd_last        = idx;
          rd_cnt         = rd_cnt + 2'd1;
          if (addr_a[idx][4]) begin
            oor_nxt[idx] = 1'b1;
            err_nxt[idx] = 1'b1;
          end else begin
            re_v[port_cnt]    = 1'b1;
            raddr_v[port_cnt] = addr_a[idx];
            port_nxt[idx]     = port_cnt;
            port_cnt          = port_cnt + 2'd1;
`ifdef PAM_ARB_BYPASS_EN
            if (pam_we && pam_waddr == addr_a[idx]) byp_nxt[idx] = 1'b1;
`endif
          end
        end
      end
    end

    wr_ptr_nxt = wr_ptr;
    if (wr_found) wr_ptr_nxt = (wr_win == LAST_REQ) ? '0 : wr_win + 1'b1;
    rd_ptr_nxt = rd_ptr;
    if (rd_any) rd_ptr_nxt = (rd_last == LAST_REQ) ? '0 : rd_last + 1'b1;
  end

  assign pam_re0    = re_v[0];
  assign pam_re1    = re_v[1];
  assign pam_re2    = re_v[2];
  assign pam_raddr0 = raddr_v[0];
  assign pam_raddr1 = raddr_v[1];
  assign pam_raddr2 = raddr_v[2];

  // Pointers and response bookkeeping; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_pend  <= '0;
      rsp_oor   <= '0;
      rsp_err_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_port[i] <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      rsp_pend  <= pend_nxt;
      rsp_oor   <= oor_nxt;
      rsp_err_q <= err_nxt;
      for (int i = 0; i < NUM_REQ; i++) rsp_port[i] <= port_nxt[i];
    end
  end

`ifdef PAM_ARB_BYPASS_EN
  // Capture the granted write so a same-address read can be merged next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit   <= '0;
      byp_wdata <= '0;
      byp_be    <= '0;
    end else begin
      byp_hit   <= byp_nxt;
      byp_wdata <= pam_wdata;
      byp_be    <= pam_be;
    end
  end

  for (g = 0; g < 8; g++) begin : g_mask
    assign byp_mask[8*g +: 8] = {8{byp_be[g]}};
  end
`endif

  assign rsp_valid = rsp_pend;
  assign rsp_err   = rsp_err_q;

  // Read data return: pick the PAM port this requester was given.
  for (g = 0; g < NUM_REQ; g++) begin : g_rsp
    logic [63:0] rd_sel;
    always_comb begin
      rd_sel = '0;
      case (rsp_port[g])
        2'd0:    rd_sel = pam_rdata0;
        2'd1:    rd_sel = pam_rdata1;
        2'd2:    rd_sel = pam_rdata2;
        default: rd_sel = '0;
      endcase
    end
`ifdef PAM_ARB_BYPASS_EN
    assign rsp_data[64*g +: 64] = (!rsp_pend[g] || rsp_oor[g]) ? 64'h0 :
                                  byp_hit[g] ? ((byp_wdata & byp_mask) | (rd_sel & ~byp_mask)) :
                                  rd_sel;
`else
    assign rsp_data[64*g +: 64] = (!rsp_pend[g] || rsp_oor[g]) ? 64'h0 : rd_sel;
`endif
  end

endmodule

// File: tb/tb_pam_access_arb.sv
// tb_pam_access_arb
//
// Self-checking bench for pam_access_arb (NUM_REQ=4). Contains a simple PAM
// memory driven by the DUT's PAM ports, and a queue-based reference model of
// the arbitration rules that predicts grants, PAM port usage and responses.
// Honors PAM_ARB_BYPASS_EN for the same-cycle read/write hazard expectation.

module tb_pam_access_arb;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_we;
  logic [5*N-1:0]    req_addr;
  logic [8*N-1:0]    req_be;
  logic [64*N-1:0]   req_wdata;
  logic [N-1:0]      req_ready, rsp_valid, rsp_err;
  logic [64*N-1:0]   rsp_data;
  logic              pam_re0, pam_re1, pam_re2;
  logic [4:0]        pam_raddr0, pam_raddr1, pam_raddr2;
  logic              pam_we;
  logic [7:0]        pam_be;
  logic [4:0]        pam_waddr;
  logic [63:0]       pam_wdata;
  logic [63:0]       pam_rdata0 = 64'h0;
  logic [63:0]       pam_rdata1 = 64'h0;
  logic [63:0]       pam_rdata2 = 64'h0;

  pam_access_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pam_re0(pam_re0), .pam_re1(pam_re1), .pam_re2(pam_re2),
    .pam_raddr0(pam_raddr0), .pam_raddr1(pam_raddr1), .pam_raddr2(pam_raddr2),
    .pam_we(pam_we), .pam_be(pam_be), .pam_waddr(pam_waddr), .pam_wdata(pam_wdata),
    .pam_rdata0(pam_rdata0), .pam_rdata1(pam_rdata1), .pam_rdata2(pam_rdata2)
  );

  always #5 clk = ~clk;

  // PAM storage: registered read ports, byte-enabled write at the same edge.
  logic [63:0] pam_mem [16] = '{default: 64'h0};
  always @(posedge clk) begin
    if (pam_re0) pam_rdata0 <= pam_mem[pam_raddr0[3:0]];
    if (pam_re1) pam_rdata1 <= pam_mem[pam_raddr1[3:0]];
    if (pam_re2) pam_rdata2 <= pam_mem[pam_raddr2[3:0]];
    if (pam_we)
      for (int b = 0; b < 8; b++)
        if (pam_be[b]) pam_mem[pam_waddr[3:0]][8*b +: 8] <= pam_wdata[8*b +: 8];
  end

  // Staged request for the next cycle.
  logic [N-1:0]    stg_valid = '0, stg_we = '0;
  logic [5*N-1:0]  stg_addr  = '0;
  logic [8*N-1:0]  stg_be    = '0;
  logic [64*N-1:0] stg_wdata = '0;

  // Reference model state.
  int          ref_wr_ptr = 0;
  int          ref_rd_ptr = 0;
  logic [63:0] ref_mem [16] = '{default: 64'h0};
  logic [N-1:0] exp_valid = '0, exp_err = '0;
  logic [63:0] exp_data [N] = '{default: 64'h0};

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic we,
                        input logic [4:0] a, input logic [7:0] be,
                        input logic [63:0] d);
    stg_valid[i]          = v;
    stg_we[i]             = we;
    stg_addr[5*i +: 5]    = a;
    stg_be[8*i +: 8]      = be;
    stg_wdata[64*i +: 64] = d;
  endtask

  task automatic clearReq();
    stg_valid = '0; stg_we = '0; stg_addr = '0; stg_be = '0; stg_wdata = '0;
  endtask

  // One cycle: drive staged inputs, check last cycle's responses and this
  // cycle's grants/PAM ports against the model, then advance the model.
  task automatic applyStimulus(input logic rst_in);
    int          wr_win;
    int          rd_wins[$];
    int          j, p;
    logic [4:0]  a, wa;
    logic [N-1:0] exp_ready;
    logic [2:0]  exp_re;
    logic [4:0]  exp_raddr [3];
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata, mask, d;

    @(posedge clk);
    #1;
    rst = rst_in;
    req_valid = stg_valid; req_we = stg_we; req_addr = stg_addr;
    req_be = stg_be; req_wdata = stg_wdata;
    #4;

    checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    checkOutput("rsp_err", 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < N; i++)
      if (exp_valid[i]) checkOutput($sformatf("rsp_data%0d", i), rsp_data[64*i +: 64], exp_data[i]);

    wr_win = -1;
    if (!rst_in) begin
      for (int k = 0; k < N; k++) begin
        j = (ref_wr_ptr + k) % N;
        if (wr_win < 0 && stg_valid[j] && stg_we[j]) wr_win = j;
      end
      for (int k = 0; k < N; k++) begin
        j = (ref_rd_ptr + k) % N;
        if (rd_wins.size() < 3 && stg_valid[j] && !stg_we[j]) rd_wins.push_back(j);
      end
    end

    exp_ready = '0;
    exp_re = '0;
    for (int q = 0; q < 3; q++) exp_raddr[q] = '0;
    p = 0;
    foreach (rd_wins[q]) begin
      exp_ready[rd_wins[q]] = 1'b1;
      a = stg_addr[5*rd_wins[q] +: 5];
      if (a < 5'd16) begin
        exp_re[p] = 1'b1;
        exp_raddr[p] = a;
        p++;
      end
    end
    exp_we = 1'b0; exp_waddr = '0; exp_be = '0; exp_wdata = '0; wa = '0;
    if (wr_win >= 0) begin
      exp_ready[wr_win] = 1'b1;
      wa = stg_addr[5*wr_win +: 5];
      if (wa < 5'd16) begin
        exp_we = 1'b1;
        exp_waddr = wa;
        exp_be = stg_be[8*wr_win +: 8];
        exp_wdata = stg_wdata[64*wr_win +: 64];
      end
    end

    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("pam_we", 64'(pam_we), 64'(exp_we));
    checkOutput("pam_waddr", 64'(pam_waddr), 64'(exp_waddr));
    checkOutput("pam_be", 64'(pam_be), 64'(exp_be));
    checkOutput("pam_wdata", pam_wdata, exp_wdata);
    checkOutput("pam_re", 64'({pam_re2, pam_re1, pam_re0}), 64'(exp_re));
    checkOutput("pam_raddr0", 64'(pam_raddr0), 64'(exp_raddr[0]));
    checkOutput("pam_raddr1", 64'(pam_raddr1), 64'(exp_raddr[1]));
    checkOutput("pam_raddr2", 64'(pam_raddr2), 64'(exp_raddr[2]));

    exp_valid = '0;
    exp_err = '0;
    if (rst_in) begin
      ref_wr_ptr = 0;
      ref_rd_ptr = 0;
    end else begin
      mask = '0;
      for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{exp_be[b]}};
      foreach (rd_wins[q]) begin
        j = rd_wins[q];
        a = stg_addr[5*j +: 5];
        exp_valid[j] = 1'b1;
        if (a >= 5'd16) begin
          exp_err[j] = 1'b1;
          exp_data[j] = 64'h0;
        end else begin
          d = ref_mem[a[3:0]];
`ifdef PAM_ARB_BYPASS_EN
          if (exp_we && exp_waddr == a) d = (exp_wdata & mask) | (d & ~mask);
`endif
          exp_data[j] = d;
        end
      end
      if (wr_win >= 0 && wa >= 5'd16) exp_err[wr_win] = 1'b1;
      if (exp_we) ref_mem[exp_waddr[3:0]] = (exp_wdata & mask) | (ref_mem[exp_waddr[3:0]] & ~mask);
      if (wr_win >= 0) ref_wr_ptr = (wr_win + 1) % N;
      if (rd_wins.size() > 0) ref_rd_ptr = (rd_wins[rd_wins.size()-1] + 1) % N;
    end
  endtask

  initial begin
    logic [4:0] ra;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_be = '0; req_wdata = '0;

    // Reset held with every requester asking to write.
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b1, 5'(8 + i), 8'hFF, {$urandom, $urandom});
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1);
      checkOutput("rst_ready", 64'(req_ready), 64'h0);
      checkOutput("rst_rsp_data", 64'(|rsp_data), 64'h0);
    end

    // Write fairness straight out of reset: 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0);
      checkOutput("wr_fair", 64'(req_ready), 64'(1 << (c % 4)));
    end

    // Write then read of entry 3.
    clearReq();
    setReq(0, 1'b1, 1'b1, 5'd3, 8'h0F, 64'h1122334455667788);
    applyStimulus(1'b0);
    clearReq();
    setReq(1, 1'b1, 1'b0, 5'd3, 8'h00, 64'h0);
    applyStimulus(1'b0);
    clearReq();
    applyStimulus(1'b0);
    checkOutput("wr_rd_data", rsp_data[127:64], 64'h0000000055667788);

    // Read fairness from a fresh read pointer.
    applyStimulus(1'b1);
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, 5'(i), 8'h00, 64'h0);
    applyStimulus(1'b0);
    checkOutput("rd_fair0", 64'(req_ready), 64'b0111);
    applyStimulus(1'b0);
    checkOutput("rd_fair1", 64'(req_ready), 64'b1011);
    applyStimulus(1'b0);
    checkOutput("rd_fair2", 64'(req_ready), 64'b1101);
    clearReq();
    applyStimulus(1'b0);

    // Out-of-range read and write.
    setReq(2, 1'b1, 1'b0, 5'd20, 8'h00, 64'h0);
    setReq(3, 1'b1, 1'b1, 5'd17, 8'hFF, 64'hDEADBEEFCAFEF00D);
    applyStimulus(1'b0);
    checkOutput("oor_pam_we", 64'(pam_we), 64'h0);
    checkOutput("oor_pam_re", 64'({pam_re2, pam_re1, pam_re0}), 64'h0);
    clearReq();
    applyStimulus(1'b0);
    checkOutput("oor_err", 64'(rsp_err), 64'b1100);
    checkOutput("oor_valid", 64'(rsp_valid), 64'b0100);
    checkOutput("oor_data", rsp_data[191:128], 64'h0);

    // Same-cycle read/write hazard on entry 5.
    setReq(0, 1'b1, 1'b1, 5'd5, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    applyStimulus(1'b0);
    clearReq();
    setReq(0, 1'b1, 1'b1, 5'd5, 8'hFF, 64'h0);
    setReq(1, 1'b1, 1'b0, 5'd5, 8'h00, 64'h0);
    applyStimulus(1'b0);
    clearReq();
    applyStimulus(1'b0);
`ifdef PAM_ARB_BYPASS_EN
    checkOutput("hazard_data", rsp_data[127:64], 64'h0);
`else
    checkOutput("hazard_data", rsp_data[127:64], 64'hAAAAAAAAAAAAAAAA);
`endif

    // Random traffic over a narrow address set to provoke collisions,
    // with occasional out-of-range addresses and reset pulses.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ra = 5'($urandom_range(0, 9));
        if (ra > 5'd7) ra = ra + 5'd12;
        setReq(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra,
               8'($urandom), {$urandom, $urandom});
      end
      applyStimulus($urandom_range(0, 39) == 0);
    end

    clearReq();
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
